// File: rtl/dvp_camera_source.sv
// dvp_camera_source: OV7670-style DVP transmitter used as an in-fabric camera stand-in.
// Drives pclk (clk/2), vsync, href and an 8-bit data bus. Frames are timed by a
// line/byte counter FSM, and the bytes come from built-in test patterns.
// Optional macro DVP_SRC_STREAM_EN replaces the pattern bytes with a valid/ready byte stream.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   enable       frame generation enable (checked at the start of each frame)
//   pattern_sel  0 h-ramp, 1 v-ramp, 2 checker, 3 constant 0x55 (latched at frame start)
//   cam_pclk     pixel clock, clk/2
//   cam_vsync    frame sync, active high
//   cam_href     line valid, active high
//   cam_data     pixel byte, 0x00 while href is low
//   frame_start  one-clk pulse on the vsync rising edge
//   frame_count  frames started since reset (wraps)
//   st_data/st_valid/st_ready/underflow  byte stream source (DVP_SRC_STREAM_EN only)
module dvp_camera_source #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned BPP         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
`ifdef DVP_SRC_STREAM_EN
  input  logic [7:0]  st_data,
  input  logic        st_valid,
  output logic        st_ready,
  output logic        underflow,
`endif
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned LINE_BYTES = (H_ACTIVE + H_BLANK) * BPP;
  localparam int unsigned ACT_BYTES  = H_ACTIVE * BPP;
  localparam int unsigned HW         = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int unsigned V_MAX_A    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned V_MAX_B    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned V_MAX      = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int unsigned VW         = $clog2(V_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t          state_q, state_n;
  logic [HW-1:0]   h_q, h_n;
  logic [VW-1:0]   v_q, v_n;
  logic [VW-1:0]   lines_last;
  logic            start_c;
  logic            vsync_n;
  logic            href_n;
  logic [7:0]      data_n;
`ifndef DVP_SRC_STREAM_EN
  logic [1:0]      pat_q;
`endif

  // All timing state advances only on the byte tick: the clk edge where pclk falls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else if (cam_pclk) begin
      state_q <= state_n;
    end
  end

  // Next position in the frame plus the bus values for that position.
  always_comb begin
    state_n    = state_q;
    h_n        = h_q;
    v_n        = v_q;
    start_c    = 1'b0;
    lines_last = '0;
    case (state_q)
      S_VSYNC:  lines_last = VW'(VSYNC_LINES - 1);
      S_VBACK:  lines_last = VW'(V_BACK - 1);
      S_ACTIVE: lines_last = VW'(V_ACTIVE - 1);
      S_VFRONT: lines_last = VW'(V_FRONT - 1);
      default:  lines_last = '0;
    endcase

    if (state_q == S_IDLE) begin
      if (enable) begin
        state_n = S_VSYNC;
        h_n     = '0;
        v_n     = '0;
        start_c = 1'b1;
      end
    end else if (h_q == HW'(LINE_BYTES - 1)) begin
      h_n = '0;
      if (v_q == lines_last) begin
        v_n = '0;
        case (state_q)
          S_VSYNC:  state_n = S_VBACK;
          S_VBACK:  state_n = S_ACTIVE;
          S_ACTIVE: state_n = S_VFRONT;
          S_VFRONT: begin
            // Back-to-back frames while enabled; otherwise park in IDLE.
            if (enable) begin
              state_n = S_VSYNC;
              start_c = 1'b1;
            end else begin
              state_n = S_IDLE;
            end
          end
          default:  state_n = S_IDLE;
        endcase
      end else begin
        v_n = v_q + VW'(1);
      end
    end else begin
      h_n = h_q + HW'(1);
    end

    vsync_n = (state_n == S_VSYNC);
    href_n  = (state_n == S_ACTIVE) && (32'(h_n) < ACT_BYTES);
    data_n  = 8'h00;
    if (href_n) begin
`ifdef DVP_SRC_STREAM_EN
      data_n = st_valid ? st_data : 8'h00;
`else
      case (pat_q)
        2'd0:    data_n = 8'(h_n);
        2'd1:    data_n = 8'(v_n);
        2'd2:    data_n = ((((32'(h_n) >> (BPP - 1)) & 32'd8) != 32'd0) ^
                           ((32'(v_n) & 32'd8) != 32'd0)) ? 8'hFF : 8'h00;
        default: data_n = 8'h55;
      endcase
`endif
    end
  end

  // Output bus, counters and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q         <= '0;
      v_q         <= '0;
      cam_pclk    <= 1'b0;
      cam_vsync   <= 1'b0;
      cam_href    <= 1'b0;
      cam_data    <= 8'h00;
      frame_start <= 1'b0;
      frame_count <= 16'h0000;
`ifdef DVP_SRC_STREAM_EN
      st_ready    <= 1'b0;
      underflow   <= 1'b0;
`else
      pat_q       <= 2'd0;
`endif
    end else begin
      cam_pclk    <= ~cam_pclk;
      frame_start <= 1'b0;
`ifdef DVP_SRC_STREAM_EN
      // Request lands in the clk just before the tick that will load an active byte.
      st_ready    <= ~cam_pclk & href_n;
`endif
      if (cam_pclk) begin
        h_q       <= h_n;
        v_q       <= v_n;
        cam_vsync <= vsync_n;
        cam_href  <= href_n;
        cam_data  <= data_n;
        if (start_c) begin
          frame_start <= 1'b1;
          frame_count <= frame_count + 16'd1;
`ifndef DVP_SRC_STREAM_EN
          pat_q       <= pattern_sel;
`endif
        end
`ifdef DVP_SRC_STREAM_EN
        if (href_n && !st_valid) begin
          underflow <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_dvp_camera_source.sv
// Directed bench for dvp_camera_source: small-frame timing, patterns, enable and reset behaviour.
module tb_dvp_camera_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, en_b;
  logic [1:0]  psel, psel_b;
  logic        pclk, vsync, href, fs;
  logic [7:0]  data;
  logic [15:0] fcnt;
  logic        pclk_b, vsync_b, href_b, fs_b;
  logic [7:0]  data_b;
  logic [15:0] fcnt_b;
`ifdef DVP_SRC_STREAM_EN
  logic [7:0]  st_data, st_data_b;
  logic        st_valid, st_valid_b, st_ready, st_ready_b, underflow, underflow_b;
`endif

  int errors = 0;
  int checks = 0;
  int drop_req = 0;

  dvp_camera_source #(
    .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1), .BPP(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(psel),
`ifdef DVP_SRC_STREAM_EN
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .underflow(underflow),
`endif
    .cam_pclk(pclk), .cam_vsync(vsync), .cam_href(href), .cam_data(data),
    .frame_start(fs), .frame_count(fcnt)
  );

  dvp_camera_source #(
    .H_ACTIVE(32), .H_BLANK(2), .V_ACTIVE(9), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1), .BPP(1)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .pattern_sel(psel_b),
`ifdef DVP_SRC_STREAM_EN
    .st_data(st_data_b), .st_valid(st_valid_b), .st_ready(st_ready_b), .underflow(underflow_b),
`endif
    .cam_pclk(pclk_b), .cam_vsync(vsync_b), .cam_href(href_b), .cam_data(data_b),
    .frame_start(fs_b), .frame_count(fcnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for a frame_start pulse on the small DUT; n = cycles taken, -1 on timeout.
  task automatic wait_fs(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < budget);
    if (!fs) n = -1;
  endtask

  // Runs from one frame_start to the next, checking bytes on the pclk-high half.
  task automatic run_frame(input int mode, output int cyc, output int hi, output int rises,
                           output int vs_cyc, output int bad_blank);
    int   idx;
    logic prev;
    string tag;
`ifdef DVP_SRC_STREAM_EN
    logic [7:0] q[$];
    logic       inc;
    logic [7:0] e;
    int         req;
    inc = 1'b0;
    req = 0;
`endif
    idx = 0; prev = 1'b0;
    cyc = 0; hi = 0; rises = 0; vs_cyc = 0; bad_blank = 0;
    tag = (mode == 0) ? "m0_byte" : "m3_byte";
    do begin
      @(negedge clk);
      cyc++;
`ifdef DVP_SRC_STREAM_EN
      if (inc) begin
        st_data = st_data + 8'd1;
        inc = 1'b0;
      end
      st_valid = 1'b1;
`endif
      if (href && !prev) rises++;
      if (href) hi++;
      if (vsync) vs_cyc++;
      if (pclk) begin
        if (href) begin
`ifdef DVP_SRC_STREAM_EN
          e = (q.size() > 0) ? q.pop_front() : 8'hxx;
          check("st_byte", 32'(data), 32'(e));
`else
          check(tag, 32'(data), (mode == 0) ? 32'(idx) : 32'h55);
`endif
          idx++;
        end else begin
          if (data != 8'h00) bad_blank++;
          idx = 0;
        end
      end
`ifdef DVP_SRC_STREAM_EN
      if (st_ready) begin
        req++;
        if (req == drop_req) st_valid = 1'b0;
        q.push_back(st_valid ? st_data : 8'h00);
        if (st_valid) inc = 1'b1;
      end
`endif
      prev = href;
    end while (!fs && cyc < 400);
  endtask

  initial begin
    int n, cyc, hi, rises, vs_cyc, bad, cnt, p0, lines, x, y;
    logic prev;
    reset = 1'b1; enable = 1'b0; en_b = 1'b0; psel = 2'd0; psel_b = 2'd2;
`ifdef DVP_SRC_STREAM_EN
    st_data = 8'h10; st_valid = 1'b1; st_data_b = 8'h00; st_valid_b = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_pclk", 32'(pclk), 32'd0);
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_href", 32'(href), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_fs", 32'(fs), 32'd0);
    check("rst_fcnt", 32'(fcnt), 32'd0);

    // Release: pclk rises on the first clk, the IDLE->VSYNC tick is the second.
    reset = 1'b0; enable = 1'b1; en_b = 1'b1;
    wait_fs(8, n);
    check("first_fs_lat", 32'(n), 32'd2);
    check("first_vsync", 32'(vsync), 32'd1);
    check("first_pclk_low", 32'(pclk), 32'd0);
    check("first_fcnt", 32'(fcnt), 32'd1);

    // Frame: 6 lines x 12 bytes x 2 clk = 144; 3 active lines of 8 bytes (16 clk).
    run_frame(0, cyc, hi, rises, vs_cyc, bad);
    check("f1_period", 32'(cyc), 32'd144);
    check("f1_href_clk", 32'(hi), 32'd48);
    check("f1_href_lines", 32'(rises), 32'd3);
    check("f1_vsync_clk", 32'(vsync_b | vsync), 32'd1);
    check("f1_vsync_len", 32'(vs_cyc), 32'd24);
    check("f1_blank_data", 32'(bad), 32'd0);
    check("f1_fcnt", 32'(fcnt), 32'd2);

    // pattern_sel already latched for frame 2; the change applies from frame 3.
    psel = 2'd3;
    run_frame(0, cyc, hi, rises, vs_cyc, bad);
    check("f2_period", 32'(cyc), 32'd144);
    check("f2_fcnt", 32'(fcnt), 32'd3);
`ifdef DVP_SRC_STREAM_EN
    check("st_no_underflow", 32'(underflow), 32'd0);
    drop_req = 3;
`endif
    run_frame(3, cyc, hi, rises, vs_cyc, bad);
    check("f3_period", 32'(cyc), 32'd144);
    check("f3_blank_data", 32'(bad), 32'd0);
`ifdef DVP_SRC_STREAM_EN
    check("st_underflow_set", 32'(underflow), 32'd1);
    drop_req = 0;
`endif

    // Drop enable during active line 1; the frame still finishes its last active line.
    cnt = 0; n = 0; prev = 1'b0;
    while (cnt < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (href && !prev) cnt++;
      prev = href;
    end
    check("found_line1", 32'(cnt), 32'd2);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    rises = 0; vs_cyc = 0; cnt = 0; prev = href;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (href && !prev) rises++;
      if (vsync) vs_cyc++;
      if (fs) cnt++;
      prev = href;
    end
    check("drop_lines_left", 32'(rises), 32'd1);
    check("drop_vsync", 32'(vs_cyc), 32'd0);
    check("drop_fs", 32'(cnt), 32'd0);
    check("drop_fcnt", 32'(fcnt), 32'd4);
    check("idle_data", 32'(data), 32'd0);
    p0 = int'(pclk);
    @(negedge clk);
    check("idle_pclk_runs", 32'(pclk), 32'(p0 ^ 1));
`ifdef DVP_SRC_STREAM_EN
    check("st_underflow_held", 32'(underflow), 32'd1);
`endif
    enable = 1'b1;
    wait_fs(6, n);
    check("reen_lat_ok", 32'(n == 1 || n == 2), 32'd1);
    check("reen_pclk_low", 32'(pclk), 32'd0);
    check("reen_fcnt", 32'(fcnt), 32'd5);

    // One-clk reset in the middle of an active line.
    n = 0;
    while (!href && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_pclk", 32'(pclk), 32'd0);
    check("mid_rst_vsync", 32'(vsync), 32'd0);
    check("mid_rst_href", 32'(href), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_fcnt", 32'(fcnt), 32'd0);
`ifdef DVP_SRC_STREAM_EN
    check("mid_rst_underflow", 32'(underflow), 32'd0);
`endif
    reset = 1'b0;
    wait_fs(8, n);
    check("post_rst_lat", 32'(n), 32'd2);
    check("post_rst_vsync", 32'(vsync), 32'd1);
    check("post_rst_fcnt", 32'(fcnt), 32'd1);

`ifndef DVP_SRC_STREAM_EN
    // Checker on 32x9, BPP=1: 8-pixel cells, inverted every 8 lines.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs_b && n < 1000);
    check("b_fs_found", 32'(fs_b), 32'd1);
    lines = 0; x = 0; prev = 1'b0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (href_b && !prev) begin
        lines++;
        x = 0;
      end
      if (pclk_b && href_b) begin
        y = lines - 1;
        if ((y == 0 || y == 8) && x < 16)
          check("chk_byte", 32'(data_b), ((x < 8) == (y == 0)) ? 32'h00 : 32'hFF);
        x++;
      end
      prev = href_b;
    end while (!fs_b && n < 1000);
    check("b_lines", 32'(lines), 32'd9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
